axis_pair_sched: RTL and testbench
==================================

Name: axis_pair_sched

Overview:
- Schedules one shared registered add/sub unit between two requesters.
- Each transaction carries a symmetry centre s and an offset f. The block computes s+f and then s-f on the same unit in consecutive cycles, and returns both results as one tagged pair.
- It sits between the symmetry-aware point generators and the downstream function-evaluation stage, so a single adder serves both axis directions and both requesters.

Parameters:
- M, 4, integer bits including sign.
- N, 8, fractional bits.
- W = M+N is a localparam (operand/result width, two's complement).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req0_valid  in  1  requester 0 has a transaction.
- req0_ready  out  1  requester 0 transaction accepted this cycle when high with valid.
- req0_s  in  W  requester 0 centre (signed).
- req0_f  in  W  requester 0 offset (signed).
- req1_valid, req1_ready, req1_s, req1_f: same as requester 0, for requester 1.
- out_valid  out  1  result pair available.
- out_ready  in  1  downstream accepts the pair.
- out_id  out  1  requester index of the pair.
- out_pos  out  W  s+f, wrapped.
- out_neg  out  W  s-f, wrapped.
- out_ovf_pos  out  1  signed overflow occurred on s+f.
- out_ovf_neg  out  1  signed overflow occurred on s-f.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - out_valid=0; out_id, out_pos, out_neg, out_ovf_* = 0.
  - Shared unit output register = 0.
  - Reset mid-transaction discards it with no output.
- FSM states: IDLE, ADD, SUB, DRAIN, OUT.
- IDLE arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant req[rr_ptr].
  - reqX_ready = (state==IDLE) & grant==X. At most one ready is high per cycle.
  - The ready of a non-granted requester stays 0.
  - Requesters must hold valid and payload stable until ready.
- Accept (handshake in IDLE at edge T):
  - Latch s, f, id.
  - rr_ptr <= ~id, only on accept.
  - state -> ADD.
- ADD (cycle T+1): unit inputs = (s, f, op=add). The unit registers its result at the end of the cycle.
- SUB (T+2): unit inputs = (s, f, op=sub); capture unit output (s+f) into pos_r and ovf_pos_r. Next state is DRAIN.
- DRAIN (T+3): capture unit output (s-f) into neg_r and ovf_neg_r. Next state is OUT.
- OUT (from T+4):
  - out_valid=1; out_* driven from the captured registers and stay stable while out_valid is high.
  - On out_ready: state -> IDLE, out_valid=0 next cycle.
  - out_ready may be high at the first OUT cycle.
- Latency and throughput:
  - Accept to out_valid = 4 cycles.
  - Best case: one transaction per 5 cycles, with out_ready held high and the next request accepted in IDLE.
  - No accept while busy; out_ready outside OUT is ignored.
- Arithmetic:
  - W-bit two's-complement wrap; no saturation.
  - ovf_pos = (s[W-1]==f[W-1]) & (sum[W-1]!=s[W-1]).
  - ovf_neg = (s[W-1]!=f[W-1]) & (diff[W-1]!=s[W-1]).
  - f = most-negative value on sub wraps (s=0, f=0x800 gives 0x800, ovf_neg=1).
- Boundary conditions:
  - Valid deasserted before ready: nothing accepted, rr_ptr unchanged.
  - Both valid across consecutive transactions: strict alternation.

Decomposition:
- Shared package holds:
  - W derivation helper, fixed-point width localparams.
  - op encoding: OP_ADD=0, OP_SUB=1 (same meaning as the existing FUNC_TYPE values).
  - FSM state enum.
- Sub-module axis_addsub: registered W-bit add/sub with runtime op input.
  - Inputs: clk, rst, a, b, op.
  - Output: registered y, with 1-cycle latency; reset clears y.

Test Plan:
- Single req0 (M=4,N=8): s=0x100, f=0x080, out_ready=1.
  - out_valid 4 cycles after accept; out_pos=0x180, out_neg=0x080, out_id=0, ovf=0/0.
- Overflow: s=0x700, f=0x200.
  - out_pos=0x900, ovf_pos=1; out_neg=0x500, ovf_neg=0.
  - Then s=0x000, f=0x800: out_neg=0x800, ovf_neg=1.
- Both requesters continuously valid after reset, with distinct payloads.
  - Grant order 0,1,0,1; out_id alternates; each result matches its payload; accepts every 5 cycles.
- Backpressure: out_ready=0 for 6 cycles in OUT.
  - out_* stable, out_valid held, both req_ready=0, busy=1.
  - On out_ready=1: IDLE next cycle and a new accept possible.
- rst pulsed in SUB state.
  - Next cycle: state IDLE, out_valid=0, rr_ptr=0, busy=0.
  - No stale pair emitted; a new req1-only request completes correctly.

Source files
------------

// File: rtl/axis_pair_sched_pkg.sv
// rtl/axis_pair_sched_pkg.sv - shared widths, op encoding and FSM states for axis_pair_sched
//
// Purpose: fixed-point width localparams, add/sub op encoding and the
// scheduler state enum shared by the interface, the add/sub unit and the top.
package axis_pair_sched_pkg;

  localparam int M = 4;  // integer bits including sign
  localparam int N = 8;  // fractional bits

  function automatic int fx_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  localparam int W = fx_width(M, N);

  // Same meaning as the FUNC_TYPE values used by the point generators.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SUB,
    ST_DRAIN,
    ST_OUT
  } state_t;

endpackage

// File: rtl/axis_pair_sched_if.sv
// rtl/axis_pair_sched_if.sv - requester and result-pair handshake bundle
//
// Purpose: groups both requester channels, the result-pair channel and busy.
// Modports:
//   slave  - scheduler view: takes requests and out_ready, drives readies/results
//   master - environment view: drives requests and out_ready, observes the rest
interface axis_pair_sched_if;
  import axis_pair_sched_pkg::*;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_s;
  logic [W-1:0] req0_f;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_s;
  logic [W-1:0] req1_f;
  logic         out_valid;
  logic         out_ready;
  logic         out_id;
  logic [W-1:0] out_pos;
  logic [W-1:0] out_neg;
  logic         out_ovf_pos;
  logic         out_ovf_neg;
  logic         busy;

  modport slave (
    input  req0_valid, req0_s, req0_f, req1_valid, req1_s, req1_f, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_pos, out_neg,
           out_ovf_pos, out_ovf_neg, busy
  );

  modport master (
    output req0_valid, req0_s, req0_f, req1_valid, req1_s, req1_f, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_pos, out_neg,
           out_ovf_pos, out_ovf_neg, busy
  );

endinterface

// File: rtl/axis_pair_sched_addsub.sv
// rtl/axis_pair_sched_addsub.sv - shared registered W-bit add/sub unit
//
// Purpose: y <= a+b or a-b (two's-complement wrap), one cycle latency.
// Ports: clk, rst (sync active-high, clears y), a, b, op, y.
module axis_addsub
  import axis_pair_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] y
);

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (op == OP_SUB) begin
      y <= a - b;
    end else begin
      y <= a + b;
    end
  end

endmodule

// File: rtl/axis_pair_sched.sv
// rtl/axis_pair_sched.sv - two-requester scheduler for one shared add/sub unit
//
// Purpose: arbitrates two requesters (round robin when both valid), then runs
// s+f and s-f through one registered add/sub unit on consecutive cycles and
// returns both results as a pair tagged with the requester index.
// Ports: clk, rst (sync active-high), bus (axis_pair_sched_if.slave).
module axis_pair_sched
  import axis_pair_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  axis_pair_sched_if.slave bus
);

  state_t       state;
  logic         rr_ptr;
  logic [W-1:0] s_r;
  logic [W-1:0] f_r;
  logic         id_r;
  logic [W-1:0] pos_r;
  logic [W-1:0] neg_r;
  logic         ovf_pos_r;
  logic         ovf_neg_r;
  logic         out_valid_r;
  logic [W-1:0] unit_y;
  op_t          unit_op;
  logic         grant;
  logic         any_valid;
  logic         idle;
  logic         accept;
  logic         ovf_pos_now;
  logic         ovf_neg_now;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = rr_ptr;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_valid      = bus.req0_valid | bus.req1_valid;
  assign idle           = (state == ST_IDLE);
  assign accept         = idle & any_valid;
  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  // The unit runs every cycle; only its SUB-cycle op matters besides ADD.
  assign unit_op = (state == ST_SUB) ? OP_SUB : OP_ADD;

  axis_addsub u_addsub (
    .clk (clk),
    .rst (rst),
    .a   (s_r),
    .b   (f_r),
    .op  (unit_op),
    .y   (unit_y)
  );

  // Overflow derived from the latched operands and the wrapped unit result.
  assign ovf_pos_now = (s_r[W-1] == f_r[W-1]) && (unit_y[W-1] != s_r[W-1]);
  assign ovf_neg_now = (s_r[W-1] != f_r[W-1]) && (unit_y[W-1] != s_r[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      s_r         <= '0;
      f_r         <= '0;
      id_r        <= 1'b0;
      pos_r       <= '0;
      neg_r       <= '0;
      ovf_pos_r   <= 1'b0;
      ovf_neg_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            s_r    <= grant ? bus.req1_s : bus.req0_s;
            f_r    <= grant ? bus.req1_f : bus.req0_f;
            id_r   <= grant;
            rr_ptr <= ~grant;
            state  <= ST_ADD;
          end
        end
        ST_ADD: begin
          state <= ST_SUB;
        end
        ST_SUB: begin
          pos_r     <= unit_y;
          ovf_pos_r <= ovf_pos_now;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          neg_r       <= unit_y;
          ovf_neg_r   <= ovf_neg_now;
          out_valid_r <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_id      = id_r;
  assign bus.out_pos     = pos_r;
  assign bus.out_neg     = neg_r;
  assign bus.out_ovf_pos = ovf_pos_r;
  assign bus.out_ovf_neg = ovf_neg_r;
  assign bus.busy        = ~idle;

endmodule

// File: tb/tb_axis_pair_sched.sv
// tb/tb_axis_pair_sched.sv - scoreboard testbench for axis_pair_sched
module tb_axis_pair_sched;
  import axis_pair_sched_pkg::*;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] f;
  } pl_t;

  typedef struct {
    logic         id;
    logic [W-1:0] pos;
    logic [W-1:0] neg;
    logic         ovp;
    logic         ovn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_pair_sched_if bus ();

  axis_pair_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  pl_t  pend0[$];
  pl_t  pend1[$];
  exp_t sb[$];
  logic glog[$];
  bit   glitch1 = 1'b0;
  bit   chk_gap = 1'b0;
  logic mrr = 1'b0;
  int   acc_cyc = 0;
  int   last_acc = -1;
  logic prev_ov = 1'b0;
  logic a0 = 1'b0;
  logic a1 = 1'b0;
  logic h0, h1, eg, hid;
  exp_t e;
  logic [W-1:0] last_pos, last_neg;
  logic         last_ovp, last_ovn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic exp_t model(input logic id, input logic [W-1:0] s, input logic [W-1:0] f);
    exp_t r;
    int sum, dif, hi, lo;
    hi    = (1 << (W - 1)) - 1;
    lo    = -(1 << (W - 1));
    sum   = sx(s) + sx(f);
    dif   = sx(s) - sx(f);
    r.id  = id;
    r.pos = sum[W-1:0];
    r.neg = dif[W-1:0];
    r.ovp = (sum > hi) || (sum < lo);
    r.ovn = (dif > hi) || (dif < lo);
    return r;
  endfunction

  // Request driver: presents the head of each pending queue, pops on handshake.
  always @(negedge clk) begin
    a0 = bus.req0_valid && bus.req0_ready && !rst;
    a1 = bus.req1_valid && bus.req1_ready && !rst;
  end

  always @(posedge clk) begin
    #1;
    if (a0) void'(pend0.pop_front());
    if (a1) void'(pend1.pop_front());
    a0 = 1'b0;
    a1 = 1'b0;
    bus.req0_valid = (pend0.size() > 0);
    if (pend0.size() > 0) begin
      bus.req0_s = pend0[0].s;
      bus.req0_f = pend0[0].f;
    end
    bus.req1_valid = (pend1.size() > 0) || glitch1;
    if (pend1.size() > 0) begin
      bus.req1_s = pend1[0].s;
      bus.req1_f = pend1[0].f;
    end
  end

  // Monitor: arbitration model, scoreboard push on accept, compare on output.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mrr      = 1'b0;
      prev_ov  = 1'b0;
      last_acc = -1;
    end else begin
      h0 = bus.req0_valid && bus.req0_ready;
      h1 = bus.req1_valid && bus.req1_ready;
      if (h0 && h1) chk("two_ready", 1, 0);
      if (h0 || h1) begin
        eg  = (bus.req0_valid && bus.req1_valid) ? mrr : bus.req1_valid;
        hid = h1;
        chk("grant", hid, eg);
        glog.push_back(hid);
        sb.push_back(model(hid, hid ? bus.req1_s : bus.req0_s, hid ? bus.req1_f : bus.req0_f));
        mrr = ~hid;
        if (chk_gap && last_acc >= 0) chk("accept_gap", cyc - last_acc, 5);
        last_acc = cyc;
        acc_cyc  = cyc;
      end
      if (bus.out_valid && !prev_ov) chk("latency", cyc - acc_cyc, 4);
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_id", bus.out_id, e.id);
          chk("out_pos", bus.out_pos, e.pos);
          chk("out_neg", bus.out_neg, e.neg);
          chk("ovf_pos", bus.out_ovf_pos, e.ovp);
          chk("ovf_neg", bus.out_ovf_neg, e.ovn);
          last_pos = bus.out_pos;
          last_neg = bus.out_neg;
          last_ovp = bus.out_ovf_pos;
          last_ovn = bus.out_ovf_neg;
        end
      end
    end
  end

  task automatic push(input bit which, input logic [W-1:0] s, input logic [W-1:0] f);
    pl_t p;
    p.s = s;
    p.f = f;
    if (which) pend1.push_back(p);
    else pend0.push_back(p);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && !bus.busy && !bus.out_valid)
        return;
    end
    chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] hold_pos, hold_neg;
  logic         hold_id;
  bit           seen;

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_s     = '0;
    bus.req0_f     = '0;
    bus.req1_s     = '0;
    bus.req1_f     = '0;
    bus.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_out_pos", bus.out_pos, 0);
    chk("rst_out_neg", bus.out_neg, 0);
    chk("rst_ovf", {bus.out_ovf_pos, bus.out_ovf_neg}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single req0 transaction.
    push(0, 12'h100, 12'h080);
    wait_done("single", 40);
    chk("t1_pos", last_pos, 12'h180);
    chk("t1_neg", last_neg, 12'h080);
    chk("t1_ovf", {last_ovp, last_ovn}, 0);

    // Overflow cases.
    push(0, 12'h700, 12'h200);
    wait_done("ovf_a", 40);
    chk("t2_pos", last_pos, 12'h900);
    chk("t2_ovp", last_ovp, 1);
    chk("t2_neg", last_neg, 12'h500);
    chk("t2_ovn", last_ovn, 0);
    push(0, 12'h000, 12'h800);
    wait_done("ovf_b", 40);
    chk("t3_neg", last_neg, 12'h800);
    chk("t3_ovn", last_ovn, 1);

    // Both requesters valid from reset: strict alternation, 5-cycle accepts.
    pulse_rst();
    glog.delete();
    chk_gap = 1'b1;
    push(0, 12'h123, 12'h011);
    push(0, 12'h0FF, 12'h3FF);
    push(1, 12'hA00, 12'h0F0);
    push(1, 12'h345, 12'hC00);
    wait_done("alternate", 100);
    chk_gap = 1'b0;
    chk("alt_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("alt_g0", glog[0], 0);
      chk("alt_g1", glog[1], 1);
      chk("alt_g2", glog[2], 0);
      chk("alt_g3", glog[3], 1);
    end

    // Backpressure in OUT; req1 valid briefly while busy, then withdrawn.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push(0, 12'h0A5, 12'h05A);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("bp_out_valid_seen", seen, 1);
    hold_pos = bus.out_pos;
    hold_neg = bus.out_neg;
    hold_id  = bus.out_id;
    glitch1  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_stable", {bus.out_id, bus.out_pos, bus.out_neg}, {hold_id, hold_pos, hold_neg});
      chk("bp_readies", {bus.req0_ready, bus.req1_ready}, 0);
      chk("bp_busy", bus.busy, 1);
    end
    @(posedge clk); #1;
    glitch1       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_valid", bus.out_valid, 0);
    // rr_ptr was not moved by the withdrawn req1: req1 wins the next tie.
    glog.delete();
    push(0, 12'h010, 12'h020);
    push(1, 12'hF00, 12'h7FF);
    wait_done("bp_after", 60);
    if (glog.size() > 0) chk("bp_tie_grant", glog[0], 1);
    else chk("bp_tie_seen", 0, 1);

    // Reset pulsed while in SUB discards the in-flight transaction.
    push(0, 12'h111, 12'h222);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (sb.size() > 0);
    end
    chk("rs_accept_seen", seen, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rs_busy", bus.busy, 0);
    chk("rs_out_valid", bus.out_valid, 0);
    repeat (6) begin
      @(negedge clk);
      chk("rs_no_stale", bus.out_valid, 0);
    end
    glog.delete();
    push(0, 12'h055, 12'h0AA);
    push(1, 12'h200, 12'h100);
    wait_done("rs_tie", 60);
    if (glog.size() > 0) chk("rs_rr_reset", glog[0], 0);
    else chk("rs_tie_seen", 0, 1);
    push(1, 12'h3C0, 12'hFC0);
    wait_done("rs_req1", 40);
    chk("rs_req1_pos", last_pos, 12'h380);
    chk("rs_req1_neg", last_neg, 12'h400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
